// File: rtl/fb_pkg.sv
// Shared types and helpers for the frame-buffer loader.
//   PIX_W   : pixel width (RGB444)
//   RD_LAT  : display read latency in cycles (address register + BRAM output register)
//   state_t : loader FSM states
//   rgb444  : packs a high byte (R,G) and a blue nibble into one pixel
package fb_pkg;

  localparam int PIX_W  = 12;
  localparam int RD_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [PIX_W-1:0] rgb444(input logic [7:0] rg, input logic [3:0] b);
    return {rg, b};
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// Small synchronous FIFO holding packed pixels waiting for a free memory slot.
//   clk, rst : clock, synchronous active-high reset
//   flush    : empties the FIFO (takes priority over push/pop)
//   push/din : write request and data; accepted when not full, or when full
//              and a pop happens in the same cycle
//   pop/dout : read request; dout shows the head entry (combinational)
//   full     : DEPTH entries stored
//   empty    : no entries stored
module pix_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty && !flush;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop) && !flush;
  assign dout    = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fb_load_arbiter.sv
// Frame loader: packs UART byte pairs into RGB444 pixels, buffers them and
// writes them into the single-port pixel memory in cycles the display does
// not use. Display reads always take the port.
//   clk, rst          : clock, synchronous active-high reset
//   rx_valid, rx_data : received UART byte strobe and data
//   load_start        : begin/restart a frame load at address 0
//   rd_req, rd_addr   : display read request and address
//   rd_valid          : memory data valid for the read requested two cycles earlier
//   mem_addr/din/we   : registered memory port
//   load_busy         : loading in progress
//   load_done         : full frame committed
//   overflow          : sticky, a pixel was dropped on a full FIFO
//   pix_count         : pixels written in the current load
module fb_load_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int NUM_PIXELS = 76800,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              load_start,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_din,
  output logic              mem_we,
  output logic              load_busy,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W:0]   pix_count
);

  localparam logic [ADDR_W:0]   NUM_C     = (ADDR_W+1)'(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_t              state_reg, state_next;
  logic                phase_reg, phase_next;
  logic [7:0]          hi_reg, hi_next;
  logic [ADDR_W-1:0]   waddr_reg, waddr_next;
  logic [ADDR_W:0]     pushed_reg, pushed_next;
  logic [ADDR_W:0]     pix_count_reg, pix_count_next;
  logic                overflow_reg, overflow_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [PIX_W-1:0]    mem_din_reg, mem_din_next;
  logic                mem_we_reg, mem_we_next;
  logic [RD_LAT-1:0]   rd_pipe_reg;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_flush;
  logic [PIX_W-1:0]    fifo_din;
  logic [PIX_W-1:0]    fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;

  pix_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A pending write drains only when the display leaves the port idle; on a
  // restart the FIFO is being flushed, so its contents must not reach memory.
  assign fifo_pop   = !rd_req && !fifo_empty && !load_start;
  assign fifo_flush = load_start;
  assign fifo_din   = rgb444(hi_reg, rx_data[3:0]);

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    hi_next        = hi_reg;
    waddr_next     = waddr_reg;
    pushed_next    = pushed_reg;
    pix_count_next = pix_count_reg;
    overflow_next  = overflow_reg;
    mem_addr_next  = mem_addr_reg;
    mem_din_next   = mem_din_reg;
    mem_we_next    = 1'b0;
    fifo_push      = 1'b0;

    case (state_reg)
      ST_IDLE: if (load_start) state_next = ST_LOAD;
      ST_LOAD: begin
        if (load_start)                  state_next = ST_LOAD;
        else if (pix_count_reg == NUM_C) state_next = ST_DONE;
      end
      ST_DONE: if (load_start) state_next = ST_LOAD;
      default: state_next = ST_IDLE;
    endcase

    // Memory port arbitration.
    if (rd_req) begin
      mem_addr_next = rd_addr;
    end else if (fifo_pop) begin
      mem_addr_next  = waddr_reg;
      mem_din_next   = fifo_dout;
      mem_we_next    = 1'b1;
      pix_count_next = pix_count_reg + 1'b1;
      // Hold at the last address so the write pointer never wraps.
      if (waddr_reg != LAST_ADDR) waddr_next = waddr_reg + 1'b1;
    end

    // Byte packing; a restart discards any byte arriving in the same cycle.
    if (load_start) begin
      phase_next     = 1'b0;
      waddr_next     = '0;
      pushed_next    = '0;
      pix_count_next = '0;
      overflow_next  = 1'b0;
    end else if (state_reg == ST_LOAD && rx_valid && pushed_reg != NUM_C) begin
      if (!phase_reg) begin
        hi_next    = rx_data;
        phase_next = 1'b1;
      end else begin
        phase_next = 1'b0;
        fifo_push  = 1'b1;
        if (fifo_full && !fifo_pop) overflow_next = 1'b1;
        else                        pushed_next   = pushed_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      phase_reg     <= 1'b0;
      hi_reg        <= '0;
      waddr_reg     <= '0;
      pushed_reg    <= '0;
      pix_count_reg <= '0;
      overflow_reg  <= 1'b0;
      mem_addr_reg  <= '0;
      mem_din_reg   <= '0;
      mem_we_reg    <= 1'b0;
      rd_pipe_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      hi_reg        <= hi_next;
      waddr_reg     <= waddr_next;
      pushed_reg    <= pushed_next;
      pix_count_reg <= pix_count_next;
      overflow_reg  <= overflow_next;
      mem_addr_reg  <= mem_addr_next;
      mem_din_reg   <= mem_din_next;
      mem_we_reg    <= mem_we_next;
      // Read data valid tracks the request through address and BRAM output registers.
      rd_pipe_reg   <= {rd_pipe_reg[RD_LAT-2:0], rd_req};
    end
  end

  assign rd_valid  = rd_pipe_reg[RD_LAT-1];
  assign mem_addr  = mem_addr_reg;
  assign mem_din   = mem_din_reg;
  assign mem_we    = mem_we_reg;
  assign load_busy = (state_reg == ST_LOAD);
  assign load_done = (state_reg == ST_DONE);
  assign overflow  = overflow_reg;
  assign pix_count = pix_count_reg;

endmodule
